// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the hazard/forwarding controller.
//   sb_entry_t     - one scoreboard slot {valid, rd, wr, is_load}
//   FWD_RF         - forward-select value meaning "use ID/EX register data"
//   REG_AW_DEFAULT - default register address width
//   RD_W           - storage width of rd in a scoreboard slot; any REG_AW
//                    up to RD_W is supported (addresses are zero-extended)
package cpu_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int RD_W           = 8;
  localparam int FWD_RF         = 0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wr;
    logic            is_load;
  } sb_entry_t;

endpackage

// File: rtl/sb_operand_match.sv
// sb_operand_match: RAW hazard check of one ID source operand against the
// scoreboard.
//   sb        in  : scoreboard entries, index 0 = EX ... DEPTH-1 = WB
//   rs        in  : source register address
//   used      in  : operand is actually read by the ID instruction
//   is_branch in  : ID instruction compares in ID (no bypass into comparator)
//   stall     out : this operand must hold the ID instruction
//   fwd_sel   out : youngest matching stage s as s+1, FWD_RF when none
// Optional feature macro: HAZARD_FORWARDING_EN (when undefined every
// match stalls).
module sb_operand_match
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int FWD_W      = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [REG_AW-1:0]     rs,
  input  logic                  used,
  input  logic                  is_branch,
  output logic                  stall,
  output logic [FWD_W-1:0]      fwd_sel
);

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [RD_W-1:0] rs_ext;
  logic            hit;

  // Walk oldest to youngest so the youngest match ends up in fwd_sel.
  // The WB slot never matches: the register file writes before it reads.
  always_comb begin
    rs_ext             = '0;
    rs_ext[REG_AW-1:0] = rs;
    stall              = 1'b0;
    fwd_sel            = FWD_W'(FWD_RF);
    hit                = 1'b0;
    for (int s = DEPTH-1; s >= 0; s--) begin
      hit = (s != DEPTH-1) && used && sb[s].valid && sb[s].wr &&
            (sb[s].rd == rs_ext) && (rs_ext != '0);
      if (hit) begin
        fwd_sel = FWD_W'(s + 1);
        // Load data only exists from LOAD_STAGE onward.
        if (is_branch || !FWD_EN || (sb[s].is_load && (s < LOAD_STAGE)))
          stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for the pipelined
// RISC-V core. Tracks destinations of in-flight instructions for DEPTH
// stages after ID (0 = EX, DEPTH-1 = WB) and resolves RAW hazards of the
// instruction in ID by stalling or by selecting an EX forwarding source.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
//   id_rd_i, id_wr_i, id_is_load_i, id_is_branch_i, br_taken_i : ID info
//   stall_o    : hold PC and IF/ID, bubble into ID/EX (combinational)
//   flush_if_o : squash IF/ID on a taken branch that issues (combinational)
//   issue_o    : ID instruction enters EX at this edge (combinational)
//   fwd_rs1_o, fwd_rs2_o : registered EX operand source, 0 = ID/EX data,
//                          s+1 = output register of stage s
// Optional feature macro: HAZARD_FORWARDING_EN. When undefined every
// non-WB match stalls and both forward selects stay 0.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int REG_AW     = REG_AW_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  input  logic [REG_AW-1:0]        id_rs1_i,
  input  logic [REG_AW-1:0]        id_rs2_i,
  input  logic                     id_rs1_used_i,
  input  logic                     id_rs2_used_i,
  input  logic [REG_AW-1:0]        id_rd_i,
  input  logic                     id_wr_i,
  input  logic                     id_is_load_i,
  input  logic                     id_is_branch_i,
  input  logic                     br_taken_i,
  output logic                     stall_o,
  output logic                     flush_if_o,
  output logic                     issue_o,
  output logic [$clog2(DEPTH)-1:0] fwd_rs1_o,
  output logic [$clog2(DEPTH)-1:0] fwd_rs2_o
);

  localparam int FWD_W = $clog2(DEPTH);

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             id_entry;
  logic                  stall_rs1;
  logic                  stall_rs2;
  logic [FWD_W-1:0]      sel_rs1;
  logic [FWD_W-1:0]      sel_rs2;

  // A write to x0 is recorded as no write so x0 can never match.
  always_comb begin
    id_entry                 = '0;
    id_entry.valid           = 1'b1;
    id_entry.rd[REG_AW-1:0]  = id_rd_i;
    id_entry.wr              = id_wr_i && (id_rd_i != '0);
    id_entry.is_load         = id_is_load_i;
  end

  sb_operand_match #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .REG_AW     (REG_AW),
    .FWD_W      (FWD_W)
  ) u_match_rs1 (
    .sb        (sb),
    .rs        (id_rs1_i),
    .used      (id_rs1_used_i),
    .is_branch (id_is_branch_i),
    .stall     (stall_rs1),
    .fwd_sel   (sel_rs1)
  );

  sb_operand_match #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .REG_AW     (REG_AW),
    .FWD_W      (FWD_W)
  ) u_match_rs2 (
    .sb        (sb),
    .rs        (id_rs2_i),
    .used      (id_rs2_used_i),
    .is_branch (id_is_branch_i),
    .stall     (stall_rs2),
    .fwd_sel   (sel_rs2)
  );

  // A stall outranks a taken branch: the branch re-evaluates next cycle.
  assign stall_o    = id_valid_i && (stall_rs1 || stall_rs2);
  assign issue_o    = id_valid_i && !stall_o;
  assign flush_if_o = br_taken_i && id_is_branch_i && id_valid_i && !stall_o;

  // Scoreboard shift: stage 0 takes the issuing instruction or a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb <= '0;
    end else begin
      sb[0] <= issue_o ? id_entry : '0;
      for (int s = 1; s < DEPTH; s++) begin
        sb[s] <= sb[s-1];
      end
    end
  end

  // Forward selects are captured with the consumer as it enters EX; the
  // stage numbering already accounts for the producer advancing one slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_rs1_o <= '0;
      fwd_rs2_o <= '0;
    end else if (FWD_EN && issue_o) begin
      fwd_rs1_o <= sel_rs1;
      fwd_rs2_o <= sel_rs2;
    end else begin
      fwd_rs1_o <= FWD_W'(FWD_RF);
      fwd_rs2_o <= FWD_W'(FWD_RF);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: DUT A (DEPTH=3, LOAD_STAGE=1) and
// DUT B (DEPTH=5, LOAD_STAGE=3). Expectations follow the build's
// HAZARD_FORWARDING_EN setting.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic       tk;
  } id_in_t;

  typedef struct {
    string      name;
    int         which;
    logic       stall;
    logic       flush;
    logic       issue;
    logic [2:0] f1;
    logic [2:0] f2;
  } exp_t;

  localparam id_in_t IDLE = '0;

  logic   clk = 1'b0;
  logic   rst_i;
  id_in_t in_a;
  id_in_t in_b;

  logic       stall_a, flush_a, issue_a;
  logic [1:0] f1_a, f2_a;
  logic       stall_b, flush_b, issue_b;
  logic [2:0] f1_b, f2_b;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event sample_ev;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(1), .REG_AW(5)) dut_a (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (in_a.valid),
    .id_rs1_i       (in_a.rs1),
    .id_rs2_i       (in_a.rs2),
    .id_rs1_used_i  (in_a.u1),
    .id_rs2_used_i  (in_a.u2),
    .id_rd_i        (in_a.rd),
    .id_wr_i        (in_a.wr),
    .id_is_load_i   (in_a.ld),
    .id_is_branch_i (in_a.br),
    .br_taken_i     (in_a.tk),
    .stall_o        (stall_a),
    .flush_if_o     (flush_a),
    .issue_o        (issue_a),
    .fwd_rs1_o      (f1_a),
    .fwd_rs2_o      (f2_a)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_STAGE(3), .REG_AW(5)) dut_b (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (in_b.valid),
    .id_rs1_i       (in_b.rs1),
    .id_rs2_i       (in_b.rs2),
    .id_rs1_used_i  (in_b.u1),
    .id_rs2_used_i  (in_b.u2),
    .id_rd_i        (in_b.rd),
    .id_wr_i        (in_b.wr),
    .id_is_load_i   (in_b.ld),
    .id_is_branch_i (in_b.br),
    .br_taken_i     (in_b.tk),
    .stall_o        (stall_b),
    .flush_if_o     (flush_b),
    .issue_o        (issue_b),
    .fwd_rs1_o      (f1_b),
    .fwd_rs2_o      (f2_b)
  );

  function automatic id_in_t op(input int rs1, input int u1, input int rs2,
                                input int u2, input int rd, input int wr,
                                input int ld, input int br, input int tk);
    id_in_t v;
    v.valid = 1'b1;
    v.rs1   = 5'(rs1);
    v.u1    = 1'(u1);
    v.rs2   = 5'(rs2);
    v.u2    = 1'(u2);
    v.rd    = 5'(rd);
    v.wr    = 1'(wr);
    v.ld    = 1'(ld);
    v.br    = 1'(br);
    v.tk    = 1'(tk);
    return v;
  endfunction

  task automatic expect_now(input int which, input string name, input logic st,
                            input logic fl, input logic is,
                            input logic [2:0] f1, input logic [2:0] f2);
    exp_t e;
    e.name  = name;
    e.which = which;
    e.stall = st;
    e.flush = fl;
    e.issue = is;
    e.f1    = f1;
    e.f2    = f2;
    q.push_back(e);
  endtask

  task automatic cyc(input int which, input id_in_t v, input string name,
                     input logic st, input logic fl, input logic is,
                     input logic [2:0] f1, input logic [2:0] f2);
    @(posedge clk);
    #1;
    if (which == 0) in_a = v;
    else            in_b = v;
    expect_now(which, name, st, fl, is, f1, f2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_a = IDLE;
      in_b = IDLE;
    end
  endtask

  always @(negedge clk) -> sample_ev;

  // Monitor: compare every queued expectation when outputs are sampled.
  initial begin : monitor
    exp_t       e;
    logic       as, af, ai;
    logic [2:0] a1, a2;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.which == 0) begin
          as = stall_a; af = flush_a; ai = issue_a;
          a1 = {1'b0, f1_a}; a2 = {1'b0, f2_a};
        end else begin
          as = stall_b; af = flush_b; ai = issue_b;
          a1 = f1_b; a2 = f2_b;
        end
        total++;
        if ({as, af, ai, a1, a2} !== {e.stall, e.flush, e.issue, e.f1, e.f2}) begin
          bad++;
          $display("FAIL %s: got stall=%0b flush=%0b issue=%0b fwd=%0d/%0d, expected stall=%0b flush=%0b issue=%0b fwd=%0d/%0d",
                   e.name, as, af, ai, a1, a2, e.stall, e.flush, e.issue, e.f1, e.f2);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "timeout");
  end

  initial begin : stim
    id_in_t add5, sub6, lw7, use7, add9, beq9, addx0, use0, p10, c11, d13;
    id_in_t q14a, q14b, u14, lw7r5;

    add5  = op(1, 1, 2, 1, 5, 1, 0, 0, 0);
    sub6  = op(5, 1, 3, 1, 6, 1, 0, 0, 0);
    lw7   = op(0, 1, 0, 0, 7, 1, 1, 0, 0);
    lw7r5 = op(5, 1, 0, 0, 7, 1, 1, 0, 0);
    use7  = op(7, 1, 7, 1, 8, 1, 0, 0, 0);
    add9  = op(1, 1, 2, 1, 9, 1, 0, 0, 0);
    beq9  = op(9, 1, 0, 1, 0, 0, 0, 1, 1);
    addx0 = op(1, 1, 2, 1, 0, 1, 0, 0, 0);
    use0  = op(0, 1, 0, 1, 3, 1, 0, 0, 0);
    p10   = op(1, 1, 2, 1, 10, 1, 0, 0, 0);
    c11   = op(11, 1, 10, 0, 12, 1, 0, 0, 0);
    d13   = op(3, 1, 10, 1, 13, 1, 0, 0, 0);
    q14a  = op(1, 1, 2, 1, 14, 1, 0, 0, 0);
    q14b  = op(3, 1, 4, 1, 14, 1, 0, 0, 0);
    u14   = op(14, 1, 14, 1, 15, 1, 0, 0, 0);

    rst_i = 1'b0;
    in_a  = IDLE;
    in_b  = IDLE;

    // Reset held: outputs cleared, flush follows a taken branch in ID.
    cyc(0, IDLE, "reset_a", 0, 0, 0, 0, 0);
    expect_now(1, "reset_b", 0, 0, 0, 0, 0);
    cyc(0, op(0, 0, 0, 0, 0, 0, 0, 1, 1), "reset_flush", 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    in_a  = IDLE;
    idle(2);

    // ALU-use back to back.
    cyc(0, add5, "alu_prod", 0, 0, 1, 0, 0);
    if (FWD) begin
      cyc(0, sub6, "alu_use", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "alu_fwd", 0, 0, 0, 1, 0);
    end else begin
      cyc(0, sub6, "alu_use_st1", 1, 0, 0, 0, 0);
      cyc(0, sub6, "alu_use_st2", 1, 0, 0, 0, 0);
      cyc(0, sub6, "alu_use_iss", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "alu_fwd", 0, 0, 0, 0, 0);
    end
    idle(3);

    // Load-use.
    cyc(0, lw7, "ld_prod", 0, 0, 1, 0, 0);
    if (FWD) begin
      cyc(0, use7, "ld_use_st1", 1, 0, 0, 0, 0);
      cyc(0, use7, "ld_use_iss", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "ld_fwd", 0, 0, 0, 2, 2);
    end else begin
      cyc(0, use7, "ld_use_st1", 1, 0, 0, 0, 0);
      cyc(0, use7, "ld_use_st2", 1, 0, 0, 0, 0);
      cyc(0, use7, "ld_use_iss", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "ld_fwd", 0, 0, 0, 0, 0);
    end
    idle(3);

    // Branch on a fresh ALU result: 2 stalls, flush only when it issues.
    cyc(0, add9, "br_prod", 0, 0, 1, 0, 0);
    cyc(0, beq9, "br_st1", 1, 0, 0, 0, 0);
    cyc(0, beq9, "br_st2", 1, 0, 0, 0, 0);
    cyc(0, beq9, "br_flush", 0, 1, 1, 0, 0);
    cyc(0, IDLE, "br_after", 0, 0, 0, 0, 0);
    idle(3);

    // x0 never creates a dependency.
    cyc(0, addx0, "x0_prod", 0, 0, 1, 0, 0);
    cyc(0, use0, "x0_use", 0, 0, 1, 0, 0);
    cyc(0, IDLE, "x0_fwd", 0, 0, 0, 0, 0);
    idle(3);

    // Unused operand ignored; older producer forwarded through rs2.
    cyc(0, p10, "unused_prod", 0, 0, 1, 0, 0);
    cyc(0, c11, "unused_rs2", 0, 0, 1, 0, 0);
    if (FWD) begin
      cyc(0, d13, "older_rs2", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "older_fwd", 0, 0, 0, 0, 2);
    end else begin
      cyc(0, d13, "older_st1", 1, 0, 0, 0, 0);
      cyc(0, d13, "older_iss", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "older_fwd", 0, 0, 0, 0, 0);
    end
    idle(3);

    // Two producers of the same register: the youngest wins.
    cyc(0, q14a, "young_p1", 0, 0, 1, 0, 0);
    cyc(0, q14b, "young_p2", 0, 0, 1, 0, 0);
    if (FWD) begin
      cyc(0, u14, "young_use", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "young_fwd", 0, 0, 0, 1, 1);
    end else begin
      cyc(0, u14, "young_st1", 1, 0, 0, 0, 0);
      cyc(0, u14, "young_st2", 1, 0, 0, 0, 0);
      cyc(0, u14, "young_iss", 0, 0, 1, 0, 0);
      cyc(0, IDLE, "young_fwd", 0, 0, 0, 0, 0);
    end
    idle(3);

    // Reset asserted mid-stall with a load in stage 0.
    if (FWD) begin
      cyc(0, add5, "rst_p1", 0, 0, 1, 0, 0);
      cyc(0, lw7r5, "rst_ld", 0, 0, 1, 0, 0);
      cyc(0, use7, "rst_stall", 1, 0, 0, 1, 0);
    end else begin
      cyc(0, lw7, "rst_ld", 0, 0, 1, 0, 0);
      cyc(0, use7, "rst_stall", 1, 0, 0, 0, 0);
    end
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    expect_now(0, "rst_mid", 0, 0, 1, 0, 0);
    -> sample_ev;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    expect_now(0, "rst_release", 0, 0, 1, 0, 0);
    cyc(0, IDLE, "rst_fwd", 0, 0, 0, 0, 0);
    idle(3);

    // Deep pipeline with late load data (DUT B).
    cyc(1, lw7, "deep_ld", 0, 0, 1, 0, 0);
    cyc(1, use7, "deep_st1", 1, 0, 0, 0, 0);
    cyc(1, use7, "deep_st2", 1, 0, 0, 0, 0);
    cyc(1, use7, "deep_st3", 1, 0, 0, 0, 0);
    if (FWD) begin
      cyc(1, use7, "deep_iss", 0, 0, 1, 0, 0);
      cyc(1, IDLE, "deep_fwd", 0, 0, 0, 4, 4);
    end else begin
      cyc(1, use7, "deep_st4", 1, 0, 0, 0, 0);
      cyc(1, use7, "deep_iss", 0, 0, 1, 0, 0);
      cyc(1, IDLE, "deep_fwd", 0, 0, 0, 0, 0);
    end
    idle(2);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined RISC-V core. It tracks destination registers of in-flight instructions through the stages after ID and detects RAW hazards against the instruction in ID. From these it produces the stall, IF flush and registered EX-stage forwarding selects. The stage count, load-result latency and forwarding mode are all configurable.

## Interface
- `DEPTH`, default 3: tracked stages after ID; stage 0 = EX, stage DEPTH-1 = WB.
- `LOAD_STAGE`, default 1: first stage whose output register holds load data.
- `REG_AW`, default 5: register address width.
- `clk_i` input, 1: clock.
- `rst_i` input, 1: asynchronous, active-low reset.
- `id_valid_i` input, 1: ID holds a valid instruction.
- `id_rs1_i`, `id_rs2_i` input, REG_AW: source registers.
- `id_rs1_used_i`, `id_rs2_used_i` input, 1: source actually read.
- `id_rd_i` input, REG_AW: destination register.
- `id_wr_i` input, 1: instruction writes rd.
- `id_is_load_i` input, 1: instruction is a load.
- `id_is_branch_i` input, 1: beq compared in ID.
- `br_taken_i` input, 1: ID comparator result.
- `stall_o` output, 1: hold PC and IF/ID, bubble into ID/EX.
- `flush_if_o` output, 1: squash IF/ID.
- `issue_o` output, 1: ID instruction enters EX this edge.
- `fwd_rs1_o`, `fwd_rs2_o` output, $clog2(DEPTH): EX operand source.

## Operation
- Scoreboard: DEPTH entries {valid, rd, wr, is_load}. Every edge, entry s moves to s+1 and entry DEPTH-1 retires.
- Entry 0 loads the ID instruction when `issue_o`, else a bubble (valid=0).
- `id_wr_i` with rd==0 is stored as wr=0. Register x0 never matches.
- Match on operand k: `idk_used`, entry valid, wr set, and rd==rs. Stage DEPTH-1 is ignored, because the register file writes before it reads.
- Non-branch hazard, with forwarding:
  - A load producer in stage s < LOAD_STAGE stalls.
  - All other matches forward.
- Branch hazard: any match in stages 0..DEPTH-2 stalls, because the ID comparator has no bypass.
- `stall_o`: `id_valid_i` and (operand-1 stall or operand-2 stall).
- `issue_o`: `id_valid_i` and not `stall_o`.
- `flush_if_o`: `br_taken_i` and `id_is_branch_i` and `id_valid_i` and not `stall_o`.
  - When a stall and a taken branch occur together, the stall wins, the flush is 0, and the branch is re-evaluated next cycle.
- Forward select, registered on the issue edge:
  - Youngest matching stage s gives the value s+1, naming the output register of stage s after it advances.
  - No match gives 0 (ID/EX data).
  - A bubble issue also gives 0.

## Timing
- `stall_o`, `flush_if_o` and `issue_o` are combinational from the ID inputs and the scoreboard state, with zero latency.
- `fwd_*_o` change only at the clock edge. They are valid for the whole cycle the consumer sits in EX.
- Load-use with defaults: exactly 1 stall cycle, then forward select 2 (MEM/WB).
- ALU-use back-to-back: 0 stall, forward select 1 (EX/MEM).
- Reset, including mid-operation, asynchronously clears all entries and both forward selects to 0.
  - `stall_o` = 0 while reset is held.
  - `flush_if_o` follows its inputs; the scoreboard is empty.
- After reset, the first valid instruction issues with no stall.

## Configuration
- `HAZARD_FORWARDING_EN` defined: forwarding behaves as described above.
- Undefined:
  - Every match in stages 0..DEPTH-2 stalls, regardless of load or branch.
  - `fwd_rs1_o` and `fwd_rs2_o` are tied to 0.
  - Branch behaviour is unchanged.

## Structure
- Shared package `cpu_pkg`:
  - `sb_entry_t` struct {valid, rd, wr, is_load}.
  - Localparam `FWD_RF` = 0.
  - Default `REG_AW`.
- One sub-module, `sb_operand_match`, instantiated per operand.
  - Inputs: the scoreboard vector, rs, used, is_branch.
  - Outputs: stall flag and youngest-stage forward select.
- The scoreboard shift register and outputs live in the top module.

## Test plan
- `add x5,x1,x2` then `sub x6,x5,x3` (DEPTH=3) → no stall; sub in EX has `fwd_rs1_o`=1, `fwd_rs2_o`=0.
- `lw x7,0(x0)` then `add x8,x7,x7` → `stall_o`=1 for 1 cycle, one bubble in entry 0; then both fwd selects = 2.
- `add x9,...` then `beq x9,x0` with `br_taken_i`=1 → stall 2 cycles, `flush_if_o`=0 throughout the stall, then `flush_if_o`=1 for 1 cycle.
- `add x0,x1,x2` then `add x3,x0,x0` → no stall, fwd 0/0. Producer with rd≠rs and `id_rs2_used_i`=0 → no stall.
- Without `HAZARD_FORWARDING_EN`: ALU-use pair → 2 stall cycles, fwd selects stay 0. DEPTH=5 with LOAD_STAGE=3: load-use → 3 stalls, then fwd = 4.
- Deassert `rst_i` mid-stall with a load in entry 0 → `stall_o` drops immediately, fwd outputs 0, next instruction issues without stall.
